// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter: one-entry buffer per execution unit, round-robin grant,
// registered write to the unified register file. Optional RV_WB_NANBOX_EN NaN-boxes f-bank writes.
module rv_wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 64,
    parameter int FLEN    = 32,
    localparam int MaxLen = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic                            clk_i,
    input  logic                            srst_i,
    input  logic [NUM_SRC-1:0]              src_valid_i,
    output logic [NUM_SRC-1:0]              src_ready_o,
    input  logic [NUM_SRC-1:0][5:0]         src_addr_i,
    input  logic [NUM_SRC-1:0][MaxLen-1:0]  src_data_i,
    output logic                            wr_en_o,
    output logic [5:0]                      wr_addr_o,
    output logic [MaxLen-1:0]               wr_data_o,
    output logic                            busy_o
);

    localparam int IdxW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]             buf_valid_q, buf_valid_d;
    logic [NUM_SRC-1:0][5:0]        buf_addr_q, buf_addr_d;
    logic [NUM_SRC-1:0][MaxLen-1:0] buf_data_q, buf_data_d;
    logic [IdxW-1:0]                ptr_q, ptr_d;
    logic                           wr_en_q, wr_en_d;
    logic [5:0]                     wr_addr_q, wr_addr_d;
    logic [MaxLen-1:0]              wr_data_q, wr_data_d;

    logic [NUM_SRC-1:0] grant;
    logic               gnt_found;
    logic [IdxW-1:0]    gnt_idx;
    logic [5:0]         gnt_addr;
    logic [MaxLen-1:0]  gnt_data;

    // First valid buffer at or above the pointer, wrapping to 0.
    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_found && buf_valid_q[(int'(ptr_q) + k) % NUM_SRC]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'((int'(ptr_q) + k) % NUM_SRC);
            end
        end
        grant[gnt_idx] = gnt_found;
    end

    always_comb begin
        gnt_addr = buf_addr_q[gnt_idx];
        gnt_data = buf_data_q[gnt_idx];
`ifdef RV_WB_NANBOX_EN
        if (gnt_addr[5]) begin
            for (int b = FLEN; b < MaxLen; b++) begin
                gnt_data[b] = 1'b1;
            end
        end
`endif
    end

    // A granted entry drains this edge, so it can be refilled at the same edge.
    assign src_ready_o = {NUM_SRC{~srst_i}} & (~buf_valid_q | grant);

    always_comb begin
        buf_valid_d = buf_valid_q & ~grant;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid_i[i] && src_ready_o[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_addr_d[i]  = src_addr_i[i];
                buf_data_d[i]  = src_data_i[i];
            end
        end
    end

    // x0 results are consumed without a write; address/data hold their last value.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_found) begin
            ptr_d = IdxW'((int'(gnt_idx) + 1) % NUM_SRC);
            if (gnt_addr != 6'd0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = gnt_addr;
                wr_data_d = gnt_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            buf_valid_q <= '0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = (|buf_valid_q) | wr_en_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed self-checking bench for rv_wb_arbiter (NUM_SRC=4, XLEN=64, FLEN=32).
module tb_rv_wb_arbiter;

    logic             clk_i = 1'b0;
    logic             srst_i;
    logic [3:0]       src_valid_i;
    logic [3:0]       src_ready_o;
    logic [3:0][5:0]  src_addr_i;
    logic [3:0][63:0] src_data_i;
    logic             wr_en_o;
    logic [5:0]       wr_addr_o;
    logic [63:0]      wr_data_o;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    rv_wb_arbiter #(.NUM_SRC(4), .XLEN(64), .FLEN(32)) u_dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_addr_i  (src_addr_i),
        .src_data_i  (src_data_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        srst_i      = 1'b1;
        src_valid_i = '0;
        tick();
        srst_i = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [5:0] addr, input logic [63:0] data);
        check_val({tag, "_en"}, 64'(wr_en_o), 64'd1);
        check_val({tag, "_addr"}, 64'(wr_addr_o), 64'(addr));
        check_val({tag, "_data"}, wr_data_o, data);
    endtask

    logic [63:0] nan_exp;

    initial begin
`ifdef RV_WB_NANBOX_EN
        nan_exp = 64'hFFFF_FFFF_3F80_0000;
`else
        nan_exp = 64'h0000_0000_3F80_0000;
`endif
        src_addr_i = '0;
        src_data_i = '0;
        src_valid_i = '0;
        srst_i = 1'b1;
        #1;
        check_val("rst_ready_comb", 64'(src_ready_o), 64'h0);
        tick();
        tick();
        check_val("rst_ready", 64'(src_ready_o), 64'h0);
        check_val("rst_wr_en", 64'(wr_en_o), 64'h0);
        check_val("rst_wr_addr", 64'(wr_addr_o), 64'h0);
        check_val("rst_wr_data", wr_data_o, 64'h0);
        check_val("rst_busy", 64'(busy_o), 64'h0);
        srst_i = 1'b0;
        #1;
        check_val("post_rst_ready", 64'(src_ready_o), 64'hF);

        // single write, two-edge latency
        src_valid_i[0] = 1'b1;
        src_addr_i[0]  = 6'd5;
        src_data_i[0]  = 64'hDEAD_BEEF_0000_0001;
        tick();
        src_valid_i = '0;
        check_val("single_en_early", 64'(wr_en_o), 64'd0);
        check_val("single_busy_buf", 64'(busy_o), 64'd1);
        tick();
        expect_write("single", 6'd5, 64'hDEAD_BEEF_0000_0001);
        check_val("single_busy_wr", 64'(busy_o), 64'd1);
        tick();
        check_val("single_en_after", 64'(wr_en_o), 64'd0);
        check_val("single_busy_after", 64'(busy_o), 64'd0);

        // contention, pointer at 0 after reset; two bursts in the same order
        do_reset();
        for (int burst = 0; burst < 2; burst++) begin
            for (int i = 0; i < 4; i++) begin
                src_addr_i[i] = 6'(i + 1);
                src_data_i[i] = 64'h100 * (i + 1) + 64'(burst);
            end
            src_valid_i = 4'hF;
            tick();
            src_valid_i = '0;
            for (int i = 0; i < 4; i++) begin
                tick();
                expect_write($sformatf("rr_b%0d_%0d", burst, i), 6'(i + 1), 64'h100 * (i + 1) + 64'(burst));
            end
            tick();
            check_val($sformatf("rr_b%0d_idle", burst), 64'(wr_en_o), 64'd0);
        end

        // move pointer to 2 with a src1 write, then sources 2 and 3 together
        src_valid_i[1] = 1'b1;
        src_addr_i[1]  = 6'd9;
        src_data_i[1]  = 64'h99;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("ptr2_setup", 6'd9, 64'h99);
        src_addr_i[2] = 6'd10; src_data_i[2] = 64'hA0;
        src_addr_i[3] = 6'd11; src_data_i[3] = 64'hB0;
        src_valid_i = 4'b1100;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("p2_first", 6'd10, 64'hA0);
        tick();
        expect_write("p2_second", 6'd11, 64'hB0);

        // x0 drop, then f0 is a real write
        src_valid_i[1] = 1'b1;
        src_addr_i[1]  = 6'd0;
        src_data_i[1]  = 64'h1234;
        tick();
        src_valid_i = '0;
        check_val("x0_en_0", 64'(wr_en_o), 64'd0);
        check_val("x0_busy", 64'(busy_o), 64'd1);
        for (int c = 1; c < 4; c++) begin
            tick();
            check_val($sformatf("x0_en_%0d", c), 64'(wr_en_o), 64'd0);
        end
        check_val("x0_busy_done", 64'(busy_o), 64'd0);
        src_valid_i[1] = 1'b1;
        src_addr_i[1]  = 6'd32;
        src_data_i[1]  = 64'h5555;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("f0", 6'd32, 64'h5555);

        // streaming from src2
        tick();
        src_addr_i[2] = 6'd12;
        for (int k = 0; k < 8; k++) begin
            src_valid_i[2] = 1'b1;
            src_data_i[2]  = 64'hC000 + 64'(k);
            check_val($sformatf("stream_ready_%0d", k), 64'(src_ready_o[2]), 64'd1);
            tick();
            if (k > 0) expect_write($sformatf("stream_%0d", k - 1), 6'd12, 64'hC000 + 64'(k - 1));
        end
        src_valid_i = '0;
        tick();
        expect_write("stream_7", 6'd12, 64'hC007);

        // NaN-box on f-bank, x-bank untouched
        src_valid_i[0] = 1'b1;
        src_addr_i[0]  = 6'd33;
        src_data_i[0]  = 64'h0000_0000_3F80_0000;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("nanbox_f", 6'd33, nan_exp);
        src_valid_i[0] = 1'b1;
        src_addr_i[0]  = 6'd6;
        src_data_i[0]  = 64'h0000_1111_3F80_0000;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("nanbox_x", 6'd6, 64'h0000_1111_3F80_0000);

        // reset with three buffered results (pointer is 1 here)
        for (int i = 0; i < 3; i++) begin
            src_addr_i[i] = 6'(7 + i);
            src_data_i[i] = 64'h700 + 64'(i);
        end
        src_valid_i = 4'b0111;
        tick();
        src_valid_i = '0;
        srst_i = 1'b1;
        #1;
        check_val("midrst_ready", 64'(src_ready_o), 64'h0);
        tick();
        srst_i = 1'b0;
        check_val("midrst_en", 64'(wr_en_o), 64'd0);
        check_val("midrst_busy", 64'(busy_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val($sformatf("midrst_quiet_%0d", c), 64'(wr_en_o), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            src_addr_i[i] = 6'(20 + i);
            src_data_i[i] = 64'h2000 + 64'(i);
        end
        src_valid_i = 4'hF;
        tick();
        src_valid_i = '0;
        tick();
        expect_write("midrst_ptr0", 6'd20, 64'h2000);
        tick();
        expect_write("midrst_ptr1", 6'd21, 64'h2001);
        tick();
        tick();
        tick();
        check_val("final_busy", 64'(busy_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
